// File: rtl/alu_exec_seq.sv
// RV32I integer execute unit driven by the 5-bit ALU control code.
// Single-cycle logic/arith/compare ops; shifts iterate one bit per cycle behind a valid/ready handshake.
module alu_exec_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0] SH_LL = 2'd0;
  localparam logic [1:0] SH_RL = 2'd1;
  localparam logic [1:0] SH_RA = 2'd2;

  state_t            r_state, w_next;
  logic [XLEN-1:0]   r_work, r_result;
  logic [SHW-1:0]    r_cnt;
  logic [1:0]        r_shtype;
  logic              r_zero, r_illegal;

  logic              w_accept, w_is_shift, w_illegal, w_last;
  logic [1:0]        w_shtype;
  logic [SHW-1:0]    w_shamt;
  logic [XLEN-1:0]   w_alu, w_first, w_step;

  function automatic logic [XLEN-1:0] shift1(input logic [XLEN-1:0] v, input logic [1:0] t);
    case (t)
      SH_LL:   shift1 = {v[XLEN-2:0], 1'b0};
      SH_RL:   shift1 = {1'b0, v[XLEN-1:1]};
      default: shift1 = {v[XLEN-1], v[XLEN-1:1]};
    endcase
  endfunction

  function automatic logic [XLEN-1:0] alu_op(input logic [4:0] c, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb;
    sa = a;
    sb = b;
    case (c)
      5'd1, 5'd2:   alu_op = a + b;
      5'd3, 5'd4:   alu_op = a | b;
      5'd5, 5'd6:   alu_op = a ^ b;
      5'd7, 5'd8:   alu_op = a & b;
      5'd9:         alu_op = a - b;
      5'd10, 5'd11: alu_op = {{(XLEN-1){1'b0}}, (sa < sb)};
      5'd12, 5'd13: alu_op = {{(XLEN-1){1'b0}}, (a < b)};
      default:      alu_op = '0;
    endcase
  endfunction

  always_comb begin
    w_is_shift = 1'b1;
    w_shtype   = SH_LL;
    case (alu_ctrl)
      5'd14, 5'd17: w_shtype = SH_LL;
      5'd15, 5'd18: w_shtype = SH_RL;
      5'd16, 5'd19: w_shtype = SH_RA;
      default:      w_is_shift = 1'b0;
    endcase
  end

  assign in_ready  = (r_state == IDLE) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_illegal = (alu_ctrl == 5'd0) || (alu_ctrl > 5'd19);
  assign w_shamt   = op_b[SHW-1:0];
  assign w_alu     = alu_op(alu_ctrl, op_a, op_b);
  // The first shift happens on the accept edge so total latency equals shamt.
  assign w_first   = shift1(op_a, w_shtype);
  assign w_step    = shift1(r_work, r_shtype);
  assign w_last    = (r_state == SHIFT) && (r_cnt == SHW'(1));

  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (!w_is_shift || (w_shamt <= SHW'(1))) w_next = DONE;
          else                                      w_next = SHIFT;
        end
      end
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_is_shift) begin
              r_illegal <= 1'b0;
              if (w_shamt == '0) begin
                r_cnt    <= '0;
                r_result <= op_a;
                r_zero   <= (op_a == '0);
              end else begin
                r_cnt <= w_shamt - SHW'(1);
                if (w_shamt == SHW'(1)) begin
                  r_result <= w_first;
                  r_zero   <= (w_first == '0);
                end
              end
            end else begin
              r_result  <= w_alu;
              r_zero    <= (w_alu == '0);
              r_illegal <= w_illegal;
            end
          end
        end
        SHIFT: begin
          r_cnt <= r_cnt - SHW'(1);
          if (w_last) begin
            r_result  <= w_step;
            r_zero    <= (w_step == '0);
            r_illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_accept) begin
      r_work   <= w_first;
      r_shtype <= w_shtype;
    end else if (r_state == SHIFT) begin
      r_work <= w_step;
    end
  end

endmodule
